store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Parametrised multi-entry store buffer between the EXE stage and the data SRAM port.
- Generalises the single write-enable gating from WB (mem_we) into a FIFO. Stores allocate speculatively at EXE, are committed in order by WB, and are drained in order to SRAM.
- Uncommitted stores can be flushed.
- Loads get combinational byte-wise forwarding from every live entry.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- ADDR_W, 32, store address width.
- DATA_W, 32, data width; BE_W = DATA_W/8 byte enables.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- st_valid  in  1  EXE presents a store this cycle.
- st_ready  out  1  entry can be allocated this cycle.
- st_addr  in  ADDR_W  store address; bytes selected by st_wen.
- st_wen  in  BE_W  store byte enables; all-zero is legal and is allocated as a no-op entry.
- st_wdata  in  DATA_W  store data, already byte-lane aligned.
- commit  in  1  WB retires the oldest uncommitted store.
- flush  in  1  discard all uncommitted entries.
- mem_en  out  1  drain request to data SRAM.
- mem_wen  out  BE_W  drain byte enables.
- mem_addr  out  ADDR_W  drain address.
- mem_wdata  out  DATA_W  drain data.
- mem_ready  in  1  SRAM accepts the drain beat this cycle.
- ld_addr  in  ADDR_W  load address to check.
- ld_hit  out  1  at least one byte forwarded.
- ld_be  out  BE_W  bytes supplied by the buffer.
- ld_data  out  DATA_W  forwarded bytes; 0 in lanes where ld_be=0.
- count  out  clog2(DEPTH+1)  live entries, pending plus committed.
- empty  out  1  count==0.
- err_commit  out  1  sticky; set by commit with no pending entry.

Behaviour:

Pointers
- head (oldest), cptr (oldest uncommitted), tail (next free).
- Each pointer is log2(DEPTH)+1 bits; the extra bit is the wrap bit.
- Invariant: head <= cptr <= tail in wrap order.
- full = (tail - head == DEPTH).

Reset
- Asynchronous reset clears all pointers and err_commit.
- Outputs during reset: mem_en=0, ld_hit=0, count=0, empty=1, st_ready=1.
- Entry storage need not be reset.

Allocate
- st_ready = ~full & ~flush. No same-cycle bypass when full.
- On st_valid & st_ready: write the entry at tail, tail+=1.
- st_valid with st_ready=0 is dropped. The upstream stage must hold.

Commit
- If cptr != tail: cptr+=1.
- If cptr == tail: ignored, err_commit<=1.
- A store allocated in the same cycle is not committable until the next cycle.

Flush
- tail <= cptr after that cycle's commit, so commit takes precedence and the committed entry survives.
- Committed entries are never flushed.
- A same-cycle allocation is dropped (st_ready=0).

Drain
- mem_en = (head != cptr), i.e. the head entry is committed.
- mem_wen, mem_addr, mem_wdata come from the head entry.
- On mem_en & mem_ready: head+=1. Zero latency, one beat per cycle maximum.
- Outputs hold stable while mem_en & ~mem_ready.
- A drain and an allocate in the same cycle both take effect, but the freed slot is not visible to st_ready until the next cycle.

Count
- count = tail - head, registered from the pointer values.

Forwarding (combinational)
- For each byte lane b, scan live entries (head..tail-1, pending and committed) whose addr[ADDR_W-1:log2(BE_W)] matches ld_addr.
- The youngest entry with wen[b]=1 supplies the byte and sets ld_be[b].
- ld_hit = |ld_be. Entries being drained this cycle still forward.

Wrap
- Pointers wrap modulo 2*DEPTH.
- Entries are ordered by (ptr - head) for the youngest-wins comparison.

Test Plan:
- Reset mid-operation: 3 entries live, 1 committed → reset asserted asynchronously mid-cycle → count=0, empty=1, mem_en=0 immediately, with no clock edge required.
- Basic path, DEPTH=4:
  - Store A=0x100, wen=1111, data=0xDEADBEEF, then commit, mem_ready=1.
  - mem_en=1 the cycle after commit with mem_addr=0x100, mem_wdata=0xDEADBEEF.
  - empty=1 one cycle after the accept.
- Full/backpressure:
  - Allocate 4 stores with mem_ready=0 → st_ready=0, count=4.
  - Commit all, raise mem_ready → drains in order 0,1,2,3 over 4 consecutive cycles.
  - st_ready returns 1 the cycle after the first drain.
- Flush with simultaneous commit:
  - 3 pending stores; commit and flush in the same cycle.
  - Result: count=1, only the oldest store drains, err_commit stays 0.
- Forwarding merge, both to 0x200, neither committed:
  - Stores wen=0011, data=0x0000AAAA, then wen=0110, data=0x00BBBB00.
  - ld_addr=0x202 gives ld_be=0111, ld_data=0x00BBBBAA, ld_hit=1.
  - ld_addr=0x204 gives ld_hit=0.
- Wrap and error:
  - Push 10 stores through the DEPTH=4 buffer with interleaved commits and drains, comparing SRAM writes against the issue order.
  - Then an extra commit on the empty buffer → err_commit=1, remaining 1 until reset.

Source files
------------

// File: rtl/store_buffer.sv
// In-order store buffer: speculative allocate at EXE, in-order commit from WB,
// in-order drain to the data SRAM, with byte-wise load forwarding from live entries.
module store_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        st_valid,
    output logic                        st_ready,
    input  logic [ADDR_W-1:0]           st_addr,
    input  logic [DATA_W/8-1:0]         st_wen,
    input  logic [DATA_W-1:0]           st_wdata,
    input  logic                        commit,
    input  logic                        flush,
    output logic                        mem_en,
    output logic [DATA_W/8-1:0]         mem_wen,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic                        mem_ready,
    input  logic [ADDR_W-1:0]           ld_addr,
    output logic                        ld_hit,
    output logic [DATA_W/8-1:0]         ld_be,
    output logic [DATA_W-1:0]           ld_data,
    output logic [$clog2(DEPTH+1)-1:0]  count,
    output logic                        empty,
    output logic                        err_commit
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OFF_W = $clog2(BE_W);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [BE_W-1:0]   wen_q  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic [PTR_W-1:0] head, cptr, tail;
    logic [PTR_W-1:0] cptr_next, tail_next, used;
    logic             full, alloc, commit_ok, drain;

    assign used      = tail - head;
    assign full      = (used == PTR_W'(DEPTH));
    assign st_ready  = ~full & ~flush;
    assign alloc     = st_valid & st_ready;
    assign commit_ok = commit & (cptr != tail);
    assign mem_en    = (head != cptr);
    assign drain     = mem_en & mem_ready;
    assign count     = CNT_W'(used);
    assign empty     = (used == '0);

    // Commit is applied before flush so a same-cycle commit survives the flush.
    always_comb begin
        cptr_next = cptr;
        tail_next = tail;
        if (commit_ok) begin
            cptr_next = cptr + PTR_W'(1);
        end
        if (flush) begin
            tail_next = cptr_next;
        end else if (alloc) begin
            tail_next = tail + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head       <= '0;
            cptr       <= '0;
            tail       <= '0;
            err_commit <= 1'b0;
        end else begin
            cptr <= cptr_next;
            tail <= tail_next;
            if (drain) begin
                head <= head + PTR_W'(1);
            end
            if (commit && (cptr == tail)) begin
                err_commit <= 1'b1;
            end
        end
    end

    // Entry payload storage carries no reset; liveness comes from the pointers.
    always_ff @(posedge clk) begin
        if (alloc) begin
            addr_q[tail[IDX_W-1:0]] <= st_addr;
            wen_q[tail[IDX_W-1:0]]  <= st_wen;
            data_q[tail[IDX_W-1:0]] <= st_wdata;
        end
    end

    assign mem_addr  = addr_q[head[IDX_W-1:0]];
    assign mem_wen   = wen_q[head[IDX_W-1:0]];
    assign mem_wdata = data_q[head[IDX_W-1:0]];

    // Walk oldest to youngest so younger matching bytes overwrite older ones.
    logic [IDX_W-1:0] fwd_idx;
    always_comb begin
        ld_be   = '0;
        ld_data = '0;
        fwd_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head[IDX_W-1:0] + IDX_W'(k);
            if ((PTR_W'(k) < used) &&
                (addr_q[fwd_idx][ADDR_W-1:OFF_W] == ld_addr[ADDR_W-1:OFF_W])) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (wen_q[fwd_idx][b]) begin
                        ld_be[b]          = 1'b1;
                        ld_data[b*8 +: 8] = data_q[fwd_idx][b*8 +: 8];
                    end
                end
            end
        end
    end

    assign ld_hit = |ld_be;

    // Byte-offset bits of the load address do not take part in the word match.
    logic unused_ld_off;
    assign unused_ld_off = ^ld_addr[OFF_W-1:0];

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: drains are checked by a scoreboard monitor,
// status and forwarding outputs by directed comparisons.
module tb_store_buffer;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  wen;
        logic [31:0] data;
    } st_t;

    logic        clk, reset;
    logic        st_valid, st_ready;
    logic [31:0] st_addr, st_wdata;
    logic [3:0]  st_wen;
    logic        commit, flush;
    logic        mem_en, mem_ready;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] ld_addr, ld_data;
    logic        ld_hit;
    logic [3:0]  ld_be;
    logic [2:0]  count;
    logic        empty, err_commit;

    int checks   = 0;
    int failures = 0;
    int drains   = 0;

    st_t unc_q[$];
    st_t exp_q[$];

    store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_wen(st_wen), .st_wdata(st_wdata),
        .commit(commit), .flush(flush),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_be(ld_be), .ld_data(ld_data),
        .count(count), .empty(empty), .err_commit(err_commit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: every accepted drain beat must match the next committed store.
    always @(negedge clk) begin
        if (!reset && mem_en && mem_ready) begin
            checks++;
            drains++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL drain_unexpected: got addr 0x%0h with no committed store expected", mem_addr);
            end else begin
                st_t e;
                e = exp_q.pop_front();
                if (mem_addr !== e.addr || mem_wen !== e.wen || mem_wdata !== e.data) begin
                    failures++;
                    $display("FAIL drain_beat: got addr 0x%0h wen 0x%0h data 0x%0h expected addr 0x%0h wen 0x%0h data 0x%0h",
                             mem_addr, mem_wen, mem_wdata, e.addr, e.wen, e.data);
                end
            end
        end
    end

    task automatic drive_store(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        st_t s;
        st_valid = 1'b1; st_addr = a; st_wen = w; st_wdata = d;
        s.addr = a; s.wen = w; s.data = d;
        unc_q.push_back(s);
    endtask

    task automatic drive_commit();
        commit = 1'b1;
        if (unc_q.size() > 0) exp_q.push_back(unc_q.pop_front());
    endtask

    task automatic drive_flush();
        flush = 1'b1;
        unc_q.delete();
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        st_valid = 1'b0; commit = 1'b0; flush = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        st_valid = 0; st_addr = 0; st_wen = 0; st_wdata = 0;
        commit = 0; flush = 0; mem_ready = 0; ld_addr = 0;
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_st_ready", 64'(st_ready), 64'd1);
        chk("rst_ld_hit", 64'(ld_hit), 64'd0);
        chk("rst_err", 64'(err_commit), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic path
        mem_ready = 1'b1;
        drive_store(32'h100, 4'hF, 32'hDEADBEEF);
        cyc();
        chk("basic_count", 64'(count), 64'd1);
        chk("basic_mem_en_pre", 64'(mem_en), 64'd0);
        drive_commit();
        cyc();
        chk("basic_mem_en", 64'(mem_en), 64'd1);
        chk("basic_mem_addr", 64'(mem_addr), 64'h100);
        chk("basic_mem_wdata", 64'(mem_wdata), 64'hDEADBEEF);
        cyc();
        chk("basic_empty", 64'(empty), 64'd1);

        // Full / backpressure
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_store(32'h300 + 32'(i * 4), 4'hF, 32'hA0A0_0000 + 32'(i));
            cyc();
        end
        chk("full_st_ready", 64'(st_ready), 64'd0);
        chk("full_count", 64'(count), 64'd4);
        for (int i = 0; i < 4; i++) begin
            drive_commit();
            cyc();
        end
        chk("full_mem_en_stalled", 64'(mem_en), 64'd1);
        mem_ready = 1'b1;
        #1;
        chk("full_st_ready_before_drain", 64'(st_ready), 64'd0);
        cyc();
        chk("full_st_ready_after_drain", 64'(st_ready), 64'd1);
        chk("full_count_after_drain", 64'(count), 64'd3);
        cyc(); cyc(); cyc();
        chk("full_empty", 64'(empty), 64'd1);

        // Flush with simultaneous commit
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_store(32'h500 + 32'(i * 4), 4'hF, 32'h5500_0000 + 32'(i));
            cyc();
        end
        drive_commit();
        drive_flush();
        #1;
        chk("flush_st_ready", 64'(st_ready), 64'd0);
        cyc();
        chk("flush_count", 64'(count), 64'd1);
        chk("flush_err", 64'(err_commit), 64'd0);
        mem_ready = 1'b1;
        cyc();
        chk("flush_empty", 64'(empty), 64'd1);
        cyc();
        chk("flush_no_extra_drain", 64'(mem_en), 64'd0);

        // Forwarding merge from two uncommitted stores
        drive_store(32'h200, 4'b0011, 32'h0000AAAA);
        cyc();
        drive_store(32'h200, 4'b0110, 32'h00BBBB00);
        cyc();
        ld_addr = 32'h202;
        #1;
        chk("fwd_be", 64'(ld_be), 64'b0111);
        chk("fwd_data", 64'(ld_data), 64'h00BBBBAA);
        chk("fwd_hit", 64'(ld_hit), 64'd1);
        ld_addr = 32'h204;
        #1;
        chk("fwd_miss_hit", 64'(ld_hit), 64'd0);
        chk("fwd_miss_data", 64'(ld_data), 64'd0);
        drive_flush();
        cyc();
        chk("fwd_flush_empty", 64'(empty), 64'd1);
        ld_addr = 32'h0;

        // Wrap: stream 10 stores with commit and drain every cycle
        mem_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (unc_q.size() > 0) drive_commit();
            drive_store(32'h400 + 32'(i * 16), (i == 3) ? 4'h0 : 4'(i + 1),
                        32'h1000_0000 + 32'(i) * 32'h0101_0101);
            #1;
            chk("wrap_st_ready", 64'(st_ready), 64'd1);
            cyc();
        end
        drive_commit();
        cyc(); cyc(); cyc();
        chk("wrap_empty", 64'(empty), 64'd1);
        chk("wrap_all_drained", 64'(exp_q.size()), 64'd0);
        chk("drain_total", 64'(drains), 64'd16);

        // Commit on an empty buffer
        drive_commit();
        cyc();
        chk("err_set", 64'(err_commit), 64'd1);
        chk("err_count", 64'(count), 64'd0);
        cyc(); cyc();
        chk("err_sticky", 64'(err_commit), 64'd1);

        // Asynchronous reset mid-cycle with live entries
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_store(32'h700 + 32'(i * 4), 4'hF, 32'h7700_0000 + 32'(i));
            cyc();
        end
        drive_commit();
        cyc();
        chk("pre_rst_count", 64'(count), 64'd3);
        chk("pre_rst_mem_en", 64'(mem_en), 64'd1);
        #2;
        reset = 1'b1;
        exp_q.delete();
        unc_q.delete();
        #1;
        chk("async_rst_count", 64'(count), 64'd0);
        chk("async_rst_empty", 64'(empty), 64'd1);
        chk("async_rst_mem_en", 64'(mem_en), 64'd0);
        chk("async_rst_err", 64'(err_commit), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        mem_ready = 1'b1;
        cyc();
        chk("post_rst_st_ready", 64'(st_ready), 64'd1);
        chk("post_rst_empty", 64'(empty), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
